dcache_lsu: RTL and testbench
=============================

Name: dcache_lsu

Overview:
- Load/store unit sitting directly upstream of the data cache, between the pipeline MEM stage and `datacache`.
- Accepts one byte/half/word load or store at a time from the pipeline and checks alignment.
- Drives the cache's edge-sensitive readable/writable strobes, waits out hit or miss latency, and performs read-modify-write for sub-word stores (cache writes whole words).
- Returns sign/zero-extended load data, and sequences the cache flush on halt.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; the only supported value is 32.
- MISS_CYCLES, 4, maximum cycles a non-hit cache access takes to complete.
- FLUSH_CYCLES, 64, cycles cache_flush is held before halted is asserted; covers 8 dirty lines.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM-stage request present
- req_ready  out  1  unit idle; request accepted when req_valid&req_ready
- req_store  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data (0 for stores)
- resp_err  out  1  misaligned/reserved-size flag, valid with resp_valid
- halt  in  1  level; request flush-and-stop
- halted  out  1  flush complete, unit stopped
- cache_addr  out  ADDR_W  word-aligned address to cache
- cache_rd  out  1  cache readable strobe
- cache_wr  out  1  cache writable strobe
- cache_wdata  out  DATA_W  word to write
- cache_rdata  in  DATA_W  cache out
- cache_hit  in  1  cache hit
- cache_flush  out  1  cache flush request

Behaviour:
- Clock and reset: clk, rst_n; reset is asynchronous and active-low, with a single clock domain.
- Reset values: state IDLE, req_ready=1, all other outputs and internal counters 0. Reset mid-operation aborts immediately; cache_rd/cache_wr/cache_flush fall asynchronously.
- Memory format is big-endian: byte lane a[1:0]=0 maps to bits[31:24]; halfword a[1]=0 maps to bits[31:16]. cache_addr = {req_addr[ADDR_W-1:2],2'b00}.
- Alignment error cases: size 11, half with a[0]=1, word with a[1:0]!=0.
  - Accepted without any cache access.
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0.
- States: IDLE, RD, MRG, WR, FLUSH, HALTED.
- IDLE:
  - req_ready=1.
  - halt=1 takes priority over req_valid and moves to FLUSH.
  - A load, or a byte/half store, moves to RD.
  - A word store moves to WR.
  - The request is latched on accept.
- RD:
  - cache_rd=1 and counter cnt starts at 0.
  - Each edge: if cache_hit=1 or cnt==MISS_CYCLES, latch cache_rdata and exit. Otherwise cnt++.
  - Exit for a load: IDLE, with resp_valid pulsed that cycle.
  - Exit for a sub-word store: MRG.
- MRG: cache_rd=cache_wr=0; merge the store lane into the latched word, then go to WR.
- WR: cache_wr=1 with cache_wdata; same completion rule as RD; then IDLE with resp_valid.
- Strobe spacing: cache_rd and cache_wr are never both high. Each strobe is low for at least one cycle between accesses, because the cache acts on strobe edges. IDLE always provides this gap.
- Back-to-back: req_ready=1 in the resp_valid cycle, so a new request may be accepted there.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load hit: 2
  - load miss: 2+MISS_CYCLES
  - word store hit: 2
  - byte/half store, both hits: 4
  - misaligned: 1
- Load extension: byte uses lane bits, half uses halfword bits; sign-extend if req_signed, else zero-extend. A word load passes through.
- FLUSH:
  - cache_flush=1, cnt counts to FLUSH_CYCLES-1, then HALTED.
  - halt deasserting during FLUSH is ignored.
  - A halt that rises while a request is in flight is serviced only after that request returns to IDLE.
- HALTED: halted=1, cache_flush held at 1, req_ready=0. Only reset leaves this state.

Decomposition:
- Package dcache_lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, a misalignment function, and counter width via $clog2 of max(MISS_CYCLES,FLUSH_CYCLES)+1.
- Sub-module dcache_lsu_lane (combinational):
  - load extract + extend from (word, addr[1:0], size, signed).
  - store merge from (old word, wdata, addr[1:0], size).
- FSM and counters live in the top module.

Test Plan:
- Load word: addr 0x40, cache_hit=1, cache_rdata=0xDEADBEEF -> cache_rd high 1 cycle, resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
- Load byte miss: addr 0x103 signed, hit=0 throughout, rdata=0x1122338F -> cache_rd held MISS_CYCLES+1=5 cycles, resp at cycle 6, rdata 0xFFFFFF8F. The same test unsigned gives 0x0000008F.
- Store half: addr 0x202, wdata 0x0000ABCD, old word 0x11223344, all hits -> RD, MRG, then WR with cache_wdata 0x1122ABCD; resp at cycle 4; cache_rd/cache_wr never overlap.
- Misaligned: word load at 0x41, and size 11 -> no cache strobe, resp_err=1 one cycle after accept.
- Halt: halt=1 with req_valid=1 in IDLE -> request not accepted; cache_flush high; halted=1 after FLUSH_CYCLES=64 cycles; req_ready stays 0.
- Reset mid-miss: rst_n low during RD cnt=2 -> cache_rd 0 asynchronously; after release req_ready=1, no resp_valid.

Source files
------------

// File: rtl/dcache_lsu_pkg.sv
// Shared encodings, FSM states and helpers for the data-cache load/store unit.
package dcache_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MRG,
    WR,
    FLUSH,
    HALTED
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  // One counter serves both the miss wait and the flush hold.
  function automatic int cnt_width(input int miss, input int flush);
    return $clog2(((miss > flush) ? miss : flush) + 1);
  endfunction

endpackage

// File: rtl/dcache_lsu_lane.sv
// Big-endian byte/half lane handling: load extract+extend and store merge.
// Purely combinational, no latency and no flow control.
module dcache_lsu_lane
  import dcache_lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    lb = 8'h00;
    case (off)
      2'd0:    lb = load_word[31:24];
      2'd1:    lb = load_word[23:16];
      2'd2:    lb = load_word[15:8];
      default: lb = load_word[7:0];
    endcase
    lh = off[1] ? load_word[15:0] : load_word[31:16];

    ldata = load_word;
    if (size == SZ_BYTE)
      ldata = {{24{sgn & lb[7]}}, lb};
    else if (size == SZ_HALF)
      ldata = {{16{sgn & lh[15]}}, lh};
  end

  always_comb begin
    mdata = old_word;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    mdata[31:24] = wdata[7:0];
        2'd1:    mdata[23:16] = wdata[7:0];
        2'd2:    mdata[15:8]  = wdata[7:0];
        default: mdata[7:0]   = wdata[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (off[1])
        mdata[15:0] = wdata[15:0];
      else
        mdata[31:16] = wdata[15:0];
    end else begin
      mdata = wdata;
    end
  end

endmodule

// File: rtl/dcache_lsu.sv
// Load/store unit in front of the data cache: one request at a time, hit 2 cycles, miss 2+MISS_CYCLES,
// sub-word store 4 (read-modify-write); req_ready low while busy, flushing, halted, or while halt is pending.
module dcache_lsu
  import dcache_lsu_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MISS_CYCLES  = 4,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              halt,
  output logic              halted,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_rd,
  output logic              cache_wr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  output logic              cache_flush
);

  localparam int CNT_W = cnt_width(MISS_CYCLES, FLUSH_CYCLES);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               accept, bad, done;

  logic               store_q, sgn_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  data_q;
  logic [31:0]        ldata, mdata;

  dcache_lsu_lane u_lane (
    .load_word (cache_rdata),
    .old_word  (data_q),
    .wdata     (wdata_q),
    .off       (addr_q[1:0]),
    .size      (size_q),
    .sgn       (sgn_q),
    .ldata     (ldata),
    .mdata     (mdata)
  );

  assign cache_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign cache_wdata = data_q;

  always_comb begin
    state_n     = state;
    req_ready   = 1'b0;
    cache_rd    = 1'b0;
    cache_wr    = 1'b0;
    cache_flush = 1'b0;
    halted      = 1'b0;
    accept      = 1'b0;
    bad         = misaligned(req_size, req_addr[1:0]);
    done        = cache_hit || (cnt == CNT_W'(MISS_CYCLES));
    case (state)
      IDLE: begin
        req_ready = !halt;
        if (halt) begin
          state_n = FLUSH;
        end else if (req_valid) begin
          accept = 1'b1;
          if (bad)
            state_n = IDLE;
          else if (req_store && (req_size == SZ_WORD))
            state_n = WR;
          else
            state_n = RD;
        end
      end
      RD: begin
        cache_rd = 1'b1;
        if (done) state_n = store_q ? MRG : IDLE;
      end
      MRG: state_n = WR;
      WR: begin
        cache_wr = 1'b1;
        if (done) state_n = IDLE;
      end
      FLUSH: begin
        cache_flush = 1'b1;
        if (cnt == CNT_W'(FLUSH_CYCLES - 1)) state_n = HALTED;
      end
      HALTED: begin
        cache_flush = 1'b1;
        halted      = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      // Counter restarts on every state change so each wait begins at zero.
      if (state_n != state)
        cnt <= '0;
      else if ((state == RD) || (state == WR) || (state == FLUSH))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q    <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (accept) begin
        store_q <= req_store;
        sgn_q   <= req_signed;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        data_q  <= req_wdata;
        if (bad) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
      end
      if ((state == RD) && done) begin
        data_q <= cache_rdata;
        if (!store_q) begin
          resp_valid <= 1'b1;
          resp_rdata <= ldata;
        end
      end
      if (state == MRG) data_q <= mdata;
      if ((state == WR) && done) resp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_lsu.sv
// Directed bench for dcache_lsu: loads, stores, misalignment, reset abort and halt flush.
module tb_dcache_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        halt, halted;
  logic [31:0] cache_addr, cache_wdata, cache_rdata;
  logic        cache_rd, cache_wr, cache_hit, cache_flush;

  int errors = 0;
  int checks = 0;
  int nrd, nwr, ovl, lat, nfl;
  logic [31:0] wd_seen, addr_seen, rd_o;
  logic        er_o, rv_seen;

  always #5 clk = ~clk;

  dcache_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .halt(halt), .halted(halted), .cache_addr(cache_addr),
    .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit), .cache_flush(cache_flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from the current cycle and waits (bounded) for resp_valid.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; ovl = 0; wd_seen = '0; addr_seen = '0;
    while (!resp_valid && lat < 50) begin
      if (cache_rd) begin nrd++; addr_seen = cache_addr; end
      if (cache_wr) begin nwr++; wd_seen = cache_wdata; addr_seen = cache_addr; end
      if (cache_rd && cache_wr) ovl++;
      tick();
      lat++;
    end
    rd_o = resp_rdata;
    er_o = resp_err;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; halt = 1'b0;
    cache_rdata = '0; cache_hit = 1'b0;
    tick();
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_strobes", {29'b0, cache_rd, cache_wr, cache_flush}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_cache_addr", cache_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Word load hit.
    cache_hit = 1'b1; cache_rdata = 32'hDEADBEEF;
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_nrd", 32'(nrd), 32'd1);
    check("lw_addr", addr_seen, 32'h40);
    check("lw_rdata", rd_o, 32'hDEADBEEF);
    check("lw_err", {31'b0, er_o}, 32'd0);
    check("b2b_ready", {31'b0, req_ready}, 32'd1);

    // Signed byte load miss, issued back-to-back in the response cycle.
    cache_hit = 1'b0; cache_rdata = 32'h1122338F;
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    check("lbs_lat", 32'(lat), 32'd6);
    check("lbs_nrd", 32'(nrd), 32'd5);
    check("lbs_addr", addr_seen, 32'h100);
    check("lbs_rdata", rd_o, 32'hFFFFFF8F);

    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    check("lbu_rdata", rd_o, 32'h0000008F);

    // Signed half load hit from the low halfword.
    cache_hit = 1'b1; cache_rdata = 32'h1234F00D;
    do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
    check("lhs_lat", 32'(lat), 32'd2);
    check("lhs_rdata", rd_o, 32'hFFFFF00D);

    // Half store read-modify-write.
    cache_rdata = 32'h11223344;
    do_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
    check("sh_lat", 32'(lat), 32'd4);
    check("sh_nrd", 32'(nrd), 32'd1);
    check("sh_nwr", 32'(nwr), 32'd1);
    check("sh_overlap", 32'(ovl), 32'd0);
    check("sh_wdata", wd_seen, 32'h1122ABCD);
    check("sh_rdata", rd_o, 32'h0);
    tick();
    check("sh_single_pulse", {31'b0, resp_valid}, 32'd0);

    // Byte store into lane 1.
    do_req(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000AA);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_wdata", wd_seen, 32'h11AA3344);

    // Word store hit skips the read.
    do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_nrd", 32'(nrd), 32'd0);
    check("sw_nwr", 32'(nwr), 32'd1);
    check("sw_wdata", wd_seen, 32'hCAFEF00D);

    // Misaligned word load and reserved size.
    do_req(1'b0, 2'b10, 1'b0, 32'h41, 32'h0);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", {31'b0, er_o}, 32'd1);
    check("mis_rdata", rd_o, 32'h0);
    check("mis_strobes", {30'b0, cache_rd, cache_wr}, 32'd0);
    do_req(1'b1, 2'b11, 1'b0, 32'h44, 32'h0);
    check("rsv_lat", 32'(lat), 32'd1);
    check("rsv_err", {31'b0, er_o}, 32'd1);
    tick();

    // Reset during a miss at cnt==2.
    cache_hit = 1'b0;
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h500;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("rm_rd_before", {31'b0, cache_rd}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_rd_async", {31'b0, cache_rd}, 32'd0);
    tick();
    rst_n = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid) rv_seen = 1'b1;
    end
    check("rm_ready", {31'b0, req_ready}, 32'd1);
    check("rm_no_resp", {31'b0, rv_seen}, 32'd0);

    // Halt has priority over a pending request; mid-flush deassert is ignored.
    halt = 1'b1; req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h40;
    #1;
    check("halt_ready", {31'b0, req_ready}, 32'd0);
    tick();
    nfl = 0; rv_seen = 1'b0;
    while (!halted && nfl < 200) begin
      if (cache_flush) nfl++;
      if (resp_valid) rv_seen = 1'b1;
      if (nfl == 10) halt = 1'b0;
      tick();
    end
    check("flush_cycles", 32'(nfl), 32'd64);
    check("halted", {31'b0, halted}, 32'd1);
    tick();
    check("halted_ready", {31'b0, req_ready}, 32'd0);
    check("halted_flush", {31'b0, cache_flush}, 32'd1);
    check("halt_no_resp", {31'b0, rv_seen | resp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
